axi_burst_reader: RTL

AXI_BURST_READER -- requirements
Module: axi_burst_reader

---
 rtl/axi_burst_reader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/axi_burst_reader.sv
// AXI4 read master that streams a memory buffer out on AXIS in fixed-length
// bursts, either as a single pass or as a circular re-read until stopped.
module axi_burst_reader #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic                axi_aclk,
  input  logic                axi_rstb,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [31:0]         cap_size,
  output logic [ADDR_W-1:0]   axi_araddr,
  output logic [7:0]          axi_arlen,
  output logic [2:0]          axi_arsize,
  output logic [1:0]          axi_arburst,
  output logic [3:0]          axi_arcache,
  output logic [2:0]          axi_arprot,
  output logic [3:0]          axi_arid,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rlast,
  input  logic                axi_rvalid,
  output logic                axi_rready,
  output logic [DATA_W-1:0]   axis_tdata,
  output logic [DATA_W/8-1:0] axis_tkeep,
  output logic                axis_tlast,
  output logic                axis_tvalid,
  input  logic                axis_tready,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic                rd_err,
  output logic [ADDR_W-1:0]   current_addr,
  output logic [7:0]          loop_count
);
  localparam int BB     = BURST_LEN * DATA_W / 8;
  localparam int LOG_BB = $clog2(BB);
  localparam logic [ADDR_W-1:0] BB_A  = ADDR_W'(BB);
  localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'(BB - 1);
  localparam logic [3:0]        MAX_O = 4'(MAX_OUTST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       nb_q, nb_d;
  logic              loop_q, loop_d;
  logic [31:0]       iss_idx_q, iss_idx_d;
  logic [31:0]       rx_idx_q, rx_idx_d;
  logic [3:0]        outst_q, outst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;
  logic              rd_err_q, rd_err_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]        loop_cnt_q, loop_cnt_d;

  logic        ar_hs, r_hs, r_last_hs, last_iss, tlast;
  logic [31:0] nb_in;

  assign ar_hs     = arvalid_q & axi_arready;
  assign r_hs      = axi_rvalid & axis_tready;
  assign r_last_hs = r_hs & axi_rlast;
  assign last_iss  = (iss_idx_q == nb_q - 32'd1);
  assign nb_in     = cap_size >> LOG_BB;
  // Only the final beat of the final burst in a pass carries tlast.
  assign tlast     = axi_rlast & (rx_idx_q == nb_q - 32'd1);

  always_comb begin
    state_d    = state_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    base_d     = base_q;
    nb_d       = nb_q;
    loop_d     = loop_q;
    iss_idx_d  = iss_idx_q;
    rx_idx_d   = rx_idx_q;
    outst_d    = outst_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    rd_err_d   = rd_err_q;
    cur_addr_d = cur_addr_q;
    loop_cnt_d = loop_cnt_q;

    if (ar_hs && !(r_last_hs && outst_q != 4'd0)) outst_d = outst_q + 4'd1;
    else if (!ar_hs && r_last_hs && outst_q != 4'd0) outst_d = outst_q - 4'd1;
    if (ar_hs) cur_addr_d = araddr_q;
    if (r_last_hs) rx_idx_d = (rx_idx_q == nb_q - 32'd1) ? 32'd0 : rx_idx_q + 32'd1;
    if (r_hs && tlast) loop_cnt_d = loop_cnt_q + 8'd1;
    if (r_hs && axi_rresp != 2'b00) rd_err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (nb_in == 32'd0) cfg_err_d = 1'b1;
          else begin
            state_d   = S_ISSUE;
            base_d    = base_addr & AMASK;
            araddr_d  = base_addr & AMASK;
            nb_d      = nb_in;
            loop_d    = loop_mode;
            iss_idx_d = 32'd0;
            rx_idx_d  = 32'd0;
            rd_err_d  = 1'b0;
            arvalid_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (ar_hs) begin
          iss_idx_d = last_iss ? 32'd0 : iss_idx_q + 32'd1;
          araddr_d  = last_iss ? base_q : araddr_q + BB_A;
        end
        // A pending AR survives stop; no new one is raised afterwards.
        if (stop || (ar_hs && last_iss && !loop_q)) begin
          state_d   = S_DRAIN;
          arvalid_d = arvalid_q & ~axi_arready;
        end else if (ar_hs || !arvalid_q) begin
          arvalid_d = (outst_d < MAX_O);
        end
      end
      S_DRAIN: begin
        if (ar_hs) arvalid_d = 1'b0;
        if (!arvalid_q && outst_q == 4'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge axi_aclk or negedge axi_rstb) begin
    if (!axi_rstb) begin
      state_q    <= S_IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      base_q     <= '0;
      nb_q       <= '0;
      loop_q     <= 1'b0;
      iss_idx_q  <= '0;
      rx_idx_q   <= '0;
      outst_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      rd_err_q   <= 1'b0;
      cur_addr_q <= '0;
      loop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      base_q     <= base_d;
      nb_q       <= nb_d;
      loop_q     <= loop_d;
      iss_idx_q  <= iss_idx_d;
      rx_idx_q   <= rx_idx_d;
      outst_q    <= outst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      rd_err_q   <= rd_err_d;
      cur_addr_q <= cur_addr_d;
      loop_cnt_q <= loop_cnt_d;
    end
  end

  assign axi_araddr   = araddr_q;
  assign axi_arlen    = 8'(BURST_LEN - 1);
  assign axi_arsize   = 3'($clog2(DATA_W / 8));
  assign axi_arburst  = 2'b01;
  assign axi_arcache  = 4'b0011;
  assign axi_arprot   = 3'b000;
  assign axi_arid     = 4'b0000;
  assign axi_arvalid  = arvalid_q;
  // Straight pass-through; tvalid is forced low while reset is held.
  assign axi_rready   = axis_tready;
  assign axis_tdata   = axi_rdata;
  assign axis_tkeep   = '1;
  assign axis_tlast   = tlast;
  assign axis_tvalid  = axi_rvalid & axi_rstb;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign rd_err       = rd_err_q;
  assign current_addr = cur_addr_q;
  assign loop_count   = loop_cnt_q;
endmodule
